ysyx_24100006_lsu: RTL and testbench

Load/store initiator between EXU and the data-memory responder. Accepts one memory op per handshake from EXU. Generates a word-aligned address, an 8-bit write mask and lane-shifted write data, issues the request over a valid/ready memory port and waits for the response. Extracts and sign/zero-extends load data, then hands the result to WBU over valid/ready.

---
 rtl/ysyx_24100006_lsu_pkg.sv | 51 +++++
 rtl/ysyx_24100006_lsu_if.sv | 27 ++
 rtl/ysyx_24100006_lsu_align.sv | 66 ++++++
 rtl/ysyx_24100006_lsu.sv | 125 ++++++++++++
 tb/tb_ysyx_24100006_lsu.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100006_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24100006_lsu_pkg
// Brief   : Shared LSU types, funct3 codes and op-legality helper.
// Rev     : 1.0  initial release
// ============================================================================
package ysyx_24100006_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    localparam int c_TIMEOUT_DEF = 255;

    // True when funct3 is a legal code for the op kind and the offset is aligned.
    function automatic logic lsu_op_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (f3)
                c_F3_SB: ok = 1'b1;
                c_F3_SH: ok = ~off[0];
                c_F3_SW: ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                c_F3_LB, c_F3_LBU: ok = 1'b1;
                c_F3_LH, c_F3_LHU: ok = ~off[0];
                c_F3_LW:           ok = (off == 2'b00);
                default:           ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24100006_lsu_if.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24100006_lsu_if
// Brief   : Data-memory request/response port between LSU and responder.
// Rev     : 1.0  initial release
// ============================================================================
interface ysyx_24100006_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24100006_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24100006_lsu_align
// Brief   : Store lane/mask generation and load byte/half extraction.
// Rev     : 1.0  initial release
// ============================================================================
module ysyx_24100006_lsu_align
    import ysyx_24100006_lsu_pkg::*;
(
    input  wire logic [2:0]  funct3,
    input  wire logic [1:0]  off,
    input  wire logic        is_store,
    input  wire logic [31:0] st_data,
    input  wire logic [31:0] ld_word,
    output logic      [7:0]  wmask,
    output logic      [31:0] wdata,
    output logic      [31:0] ld_data
);
    logic [4:0]  w_bit_off;
    logic [3:0]  w_lane;
    logic [31:0] w_ld_sh;

    assign w_bit_off = {off, 3'b000};
    assign w_ld_sh   = ld_word >> w_bit_off;

    always_comb begin
        wmask  = 8'h00;
        wdata  = 32'h0;
        w_lane = 4'b0000;
        if (is_store) begin
            case (funct3)
                c_F3_SB: begin
                    w_lane = 4'b0001 << off;
                    wdata  = {24'h0, st_data[7:0]} << w_bit_off;
                end
                c_F3_SH: begin
                    w_lane = 4'b0011 << off;
                    wdata  = {16'h0, st_data[15:0]} << w_bit_off;
                end
                c_F3_SW: begin
                    w_lane = 4'b1111;
                    wdata  = st_data;
                end
                default: begin
                    w_lane = 4'b0000;
                    wdata  = 32'h0;
                end
            endcase
            wmask = {4'b0000, w_lane};
        end
    end

    // LW is always aligned, so the shifted word equals the raw word.
    always_comb begin
        ld_data = 32'h0;
        case (funct3)
            c_F3_LB:  ld_data = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
            c_F3_LH:  ld_data = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
            c_F3_LW:  ld_data = w_ld_sh;
            c_F3_LBU: ld_data = {24'h0, w_ld_sh[7:0]};
            c_F3_LHU: ld_data = {16'h0, w_ld_sh[15:0]};
            default:  ld_data = 32'h0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ysyx_24100006_lsu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24100006_lsu
// Brief   : Single-outstanding load/store initiator between EXU, memory and WBU.
// Rev     : 1.0  initial release
// ============================================================================
module ysyx_24100006_lsu
    import ysyx_24100006_lsu_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEF,
    parameter int TO_W    = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        in_valid,
    output logic             in_ready,
    input  wire logic        in_ren,
    input  wire logic        in_wen,
    input  wire logic [2:0]  in_funct3,
    input  wire logic [31:0] in_addr,
    input  wire logic [31:0] in_wdata,
    output logic             out_valid,
    input  wire logic        out_ready,
    output logic      [31:0] out_rdata,
    output logic             out_err,
    ysyx_24100006_lsu_if.master mem
);
    localparam logic [TO_W-1:0] c_TO_MAX = TO_W'(TIMEOUT);

    lsu_state_e      r_state, w_state_nxt;
    logic            r_wen;
    logic [2:0]      r_funct3;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [TO_W-1:0] r_cnt;

    logic            w_mem_op;
    logic            w_op_ok;
    logic            w_timeout;
    logic [7:0]      w_wmask;
    logic [31:0]     w_wdata;
    logic [31:0]     w_ld_data;

    assign w_mem_op  = in_ren | in_wen;
    assign w_op_ok   = lsu_op_ok(in_wen, in_funct3, in_addr[1:0]);
    assign w_timeout = (r_cnt == c_TO_MAX);

    ysyx_24100006_lsu_align u_align (
        .funct3   (r_funct3),
        .off      (r_addr[1:0]),
        .is_store (r_wen),
        .st_data  (r_wdata),
        .ld_word  (mem.mem_rdata),
        .wmask    (w_wmask),
        .wdata    (w_wdata),
        .ld_data  (w_ld_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = (w_mem_op && w_op_ok) ? ST_REQ : ST_DONE;
            ST_REQ:  if (mem.mem_req_ready) w_state_nxt = ST_WAIT;
            ST_WAIT: if (mem.mem_resp_valid || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wen    <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (in_valid) begin
                        r_wen    <= in_wen;
                        r_funct3 <= in_funct3;
                        r_addr   <= in_addr;
                        r_wdata  <= in_wdata;
                        r_rdata  <= 32'h0;
                        r_err    <= w_mem_op & ~w_op_ok;
                    end
                end
                ST_WAIT: begin
                    // A response arriving on the last timeout cycle still wins.
                    if (mem.mem_resp_valid) begin
                        r_rdata <= r_wen ? 32'h0 : w_ld_data;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready          = (r_state == ST_IDLE);
    assign out_valid         = (r_state == ST_DONE);
    assign out_rdata         = r_rdata;
    assign out_err           = r_err;
    assign mem.mem_req_valid = (r_state == ST_REQ);
    assign mem.mem_we        = r_wen;
    assign mem.mem_addr      = {r_addr[31:2], 2'b00};
    assign mem.mem_wdata     = w_wdata;
    assign mem.mem_wmask     = w_wmask;
endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_24100006_lsu
// Brief   : Directed self-checking bench for ysyx_24100006_lsu.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ysyx_24100006_lsu;
    localparam int c_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_ren, in_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    int n_total = 0;
    int n_bad   = 0;

    ysyx_24100006_lsu_if m_if ();

    always #5 clk = ~clk;

    ysyx_24100006_lsu #(.TIMEOUT(c_TIMEOUT), .TO_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ren    (in_ren),
        .in_wen    (in_wen),
        .in_funct3 (in_funct3),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_err   (out_err),
        .mem       (m_if.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wen, input logic ren, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        in_valid = 1'b1; in_wen = wen; in_ren = ren; in_funct3 = f3;
        in_addr = addr; in_wdata = wd;
        @(negedge clk);
        in_valid = 1'b0; in_wen = 1'b0; in_ren = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic wen, input logic ren,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] mrd, input bit use_mem,
                          input logic [31:0] e_addr, input logic [7:0] e_mask,
                          input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                          input logic e_err, input int rdy_dly, input int resp_dly,
                          input int ordy_dly);
        check({tag, "/in_ready"}, in_ready, 1'b1);
        issue(wen, ren, f3, addr, wd);
        if (use_mem) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                check({tag, "/req_valid"}, m_if.mem_req_valid, 1'b1);
                check({tag, "/addr"}, m_if.mem_addr, e_addr);
                check({tag, "/wmask"}, m_if.mem_wmask, e_mask);
                check({tag, "/wdata"}, m_if.mem_wdata, e_wdata);
                check({tag, "/we"}, m_if.mem_we, wen);
                if (i < rdy_dly) begin
                    m_if.mem_resp_valid = (i == 0);
                    m_if.mem_rdata = 32'hBAD0BAD0;
                    @(negedge clk);
                    m_if.mem_resp_valid = 1'b0;
                end
            end
            m_if.mem_req_ready = 1'b1;
            @(negedge clk);
            m_if.mem_req_ready = 1'b0;
            for (int i = 0; i < resp_dly; i++) begin
                check({tag, "/no_req2"}, m_if.mem_req_valid, 1'b0);
                check({tag, "/wait_ov"}, out_valid, 1'b0);
                @(negedge clk);
            end
            m_if.mem_resp_valid = 1'b1;
            m_if.mem_rdata = mrd;
            @(negedge clk);
            m_if.mem_resp_valid = 1'b0;
            m_if.mem_rdata = 32'h0;
        end else begin
            check({tag, "/no_req"}, m_if.mem_req_valid, 1'b0);
        end
        for (int i = 0; i <= ordy_dly; i++) begin
            check({tag, "/out_valid"}, out_valid, 1'b1);
            check({tag, "/rdata"}, out_rdata, e_rdata);
            check({tag, "/err"}, out_err, e_err);
            check({tag, "/done_req"}, m_if.mem_req_valid, 1'b0);
            if (i < ordy_dly) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/ov_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_funct3 = 3'b000;
        in_addr = 32'h0; in_wdata = 32'h0; out_ready = 1'b0;
        m_if.mem_req_ready = 1'b0; m_if.mem_resp_valid = 1'b0; m_if.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst/in_ready", in_ready, 1'b1);
        check("rst/out_valid", out_valid, 1'b0);
        check("rst/req_valid", m_if.mem_req_valid, 1'b0);
        check("rst/we", m_if.mem_we, 1'b0);
        check("rst/err", out_err, 1'b0);
        check("rst/rdata", out_rdata, 32'h0);
        check("rst/addr", m_if.mem_addr, 32'h0);
        check("rst/wmask", m_if.mem_wmask, 32'h0);
        check("rst/wdata", m_if.mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stores
        run_op("sw", 1, 0, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 1,
               32'h8000_0004, 8'h0F, 32'hDEAD_BEEF, 32'h0, 0, 0, 2, 0);
        run_op("sb", 1, 0, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 1,
               32'h8000_0000, 8'h08, 32'hA500_0000, 32'h0, 0, 0, 1, 0);
        run_op("sh", 1, 0, 3'b001, 32'h8000_0002, 32'h1234_BEEF, 32'h0, 1,
               32'h8000_0000, 8'h0C, 32'hBEEF_0000, 32'h0, 0, 0, 0, 0);
        run_op("sw_rw", 1, 1, 3'b010, 32'h8000_0008, 32'h0102_0304, 32'hFFFF_FFFF, 1,
               32'h8000_0008, 8'h0F, 32'h0102_0304, 32'h0, 0, 0, 1, 0);
        // Loads of 0x80F17F22
        run_op("lb", 0, 1, 3'b000, 32'h8000_0013, 32'h0, 32'h80F1_7F22, 1,
               32'h8000_0010, 8'h00, 32'h0, 32'hFFFF_FF80, 0, 0, 1, 0);
        run_op("lbu", 0, 1, 3'b100, 32'h8000_0013, 32'h0, 32'h80F1_7F22, 1,
               32'h8000_0010, 8'h00, 32'h0, 32'h0000_0080, 0, 0, 1, 0);
        run_op("lh", 0, 1, 3'b001, 32'h8000_0022, 32'h0, 32'h80F1_7F22, 1,
               32'h8000_0020, 8'h00, 32'h0, 32'hFFFF_80F1, 0, 0, 1, 0);
        run_op("lhu", 0, 1, 3'b101, 32'h8000_0022, 32'h0, 32'h80F1_7F22, 1,
               32'h8000_0020, 8'h00, 32'h0, 32'h0000_80F1, 0, 0, 1, 0);
        run_op("lb1", 0, 1, 3'b000, 32'h8000_0021, 32'h0, 32'h80F1_7F22, 1,
               32'h8000_0020, 8'h00, 32'h0, 32'h0000_007F, 0, 0, 1, 0);
        run_op("lw", 0, 1, 3'b010, 32'h8000_0030, 32'h0, 32'h80F1_7F22, 1,
               32'h8000_0030, 8'h00, 32'h0, 32'h80F1_7F22, 0, 0, 1, 0);
        // Errors and non-memory op
        run_op("lw_mis", 0, 1, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0,
               32'h0, 8'h00, 32'h0, 32'h0, 1, 0, 0, 0);
        run_op("ld_011", 0, 1, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0,
               32'h0, 8'h00, 32'h0, 32'h0, 1, 0, 0, 0);
        run_op("st_100", 1, 0, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0,
               32'h0, 8'h00, 32'h0, 32'h0, 1, 0, 0, 0);
        run_op("lh_mis", 0, 1, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 0,
               32'h0, 8'h00, 32'h0, 32'h0, 1, 0, 0, 0);
        run_op("nop", 0, 0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0,
               32'h0, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);
        // Back-pressure on both sides
        run_op("stall", 0, 1, 3'b010, 32'h8000_0040, 32'h0, 32'hCAFE_BABE, 1,
               32'h8000_0040, 8'h00, 32'h0, 32'hCAFE_BABE, 0, 5, 3, 3);

        // Timeout
        issue(0, 1, 3'b010, 32'h8000_0050, 32'h0);
        check("to/req_valid", m_if.mem_req_valid, 1'b1);
        m_if.mem_req_ready = 1'b1;
        @(negedge clk);
        m_if.mem_req_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("to/out_valid", out_valid, 1'b1);
        check("to/err", out_err, 1'b1);
        check("to/rdata", out_rdata, 32'h0);
        check("to/not_early", cyc >= c_TIMEOUT, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Async reset during REQ
        issue(0, 1, 3'b010, 32'h8000_0060, 32'h0);
        check("rreq/req_valid", m_if.mem_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rreq/req_valid0", m_if.mem_req_valid, 1'b0);
        check("rreq/in_ready", in_ready, 1'b1);
        check("rreq/out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset during WAIT
        issue(0, 1, 3'b010, 32'h8000_0070, 32'h0);
        m_if.mem_req_ready = 1'b1;
        @(negedge clk);
        m_if.mem_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rwait/in_ready_pre", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rwait/in_ready", in_ready, 1'b1);
        check("rwait/out_valid", out_valid, 1'b0);
        check("rwait/req_valid", m_if.mem_req_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("post_rst", 0, 1, 3'b100, 32'h8000_0081, 32'h0, 32'h80F1_7F22, 1,
               32'h8000_0080, 8'h00, 32'h0, 32'h0000_007F, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
